// File: rtl/imem_fetch_if.sv
// Fetch request/response and byte-load port bundle for imem_fetch.
// The master side is the fetch stage and program loader; the slave side is the store.
interface imem_fetch_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_instr;
  logic              rsp_fault;
  logic [ADDR_W-1:0] rsp_addr;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0]        ld_data;

  modport master (
    output req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
    input  req_ready, rsp_valid, rsp_instr, rsp_fault, rsp_addr
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
    output req_ready, rsp_valid, rsp_instr, rsp_fault, rsp_addr
  );
endinterface

// File: rtl/imem_fetch.sv
// Clocked big-endian instruction store with a stallable read pipeline and a byte-load port.
// Define IMEM_ALIGN_CHECK_EN to fault fetches whose address is not word aligned.
module imem_fetch #(
  parameter int unsigned DEPTH_BYTES = 512,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned LATENCY     = 1
) (
  input logic         clk,
  input logic         rst_n,
  imem_fetch_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(DEPTH_BYTES);
  localparam logic [ADDR_W:0] DepthExt = (ADDR_W+1)'(DEPTH_BYTES);
  localparam logic [ADDR_W:0] LastOff  = (ADDR_W+1)'(3);

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("imem_fetch: LATENCY must be in 1..4");
  end

  typedef struct packed {
    logic              valid;
    logic [31:0]       instr;
    logic              fault;
    logic [ADDR_W-1:0] addr;
  } stage_t;

  logic [7:0] mem [DEPTH_BYTES];
  stage_t [LATENCY-1:0] pipe_q;
  stage_t               head_d;

  logic              stall;
  logic              accept;
  logic              in_range;
  logic              misaligned;
  logic              fault;
  logic              ld_in_range;
  logic [ADDR_W:0]   last_byte;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       word;

  assign stall         = pipe_q[LATENCY-1].valid && !bus.rsp_ready;
  assign bus.req_ready = !stall && !bus.ld_en;
  assign accept        = bus.req_valid && bus.req_ready;

  // Extra carry bit keeps addresses near the top of the address space from wrapping low.
  assign last_byte = {1'b0, bus.req_addr} + LastOff;
  assign in_range  = last_byte < DepthExt;

`ifdef IMEM_ALIGN_CHECK_EN
  assign misaligned = bus.req_addr[1:0] != 2'b00;
`else
  assign misaligned = 1'b0;
`endif

  assign fault = !in_range || misaligned;
  assign idx   = bus.req_addr[IDX_W-1:0];

  always_comb begin
    word = '0;
    if (!fault) begin
      word = {mem[idx], mem[idx + IDX_W'(1)], mem[idx + IDX_W'(2)], mem[idx + IDX_W'(3)]};
    end
  end

  // Bubbles enter stage 0 with all fields zero.
  always_comb begin
    head_d = '0;
    if (accept) begin
      head_d.valid = 1'b1;
      head_d.instr = word;
      head_d.fault = fault;
      head_d.addr  = bus.req_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else if (!stall) begin
      pipe_q[0] <= head_d;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  // The store is deliberately outside reset so a program survives a core reset.
  assign ld_in_range = bus.ld_addr < ADDR_W'(DEPTH_BYTES);

  always_ff @(posedge clk) begin
    if (bus.ld_en && ld_in_range) begin
      mem[bus.ld_addr[IDX_W-1:0]] <= bus.ld_data;
    end
  end

  assign bus.rsp_valid = pipe_q[LATENCY-1].valid;
  assign bus.rsp_instr = pipe_q[LATENCY-1].instr;
  assign bus.rsp_fault = pipe_q[LATENCY-1].fault;
  assign bus.rsp_addr  = pipe_q[LATENCY-1].addr;

endmodule

// File: tb/tb_imem_fetch.sv
// Bench for imem_fetch: three instances (LATENCY 1, 2, 3) share one stimulus stream and are
// checked every cycle against a queue-based model of in-flight responses.
module tb_imem_fetch;
  localparam int unsigned DEPTH = 512;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        rsp_ready;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [7:0]  ld_data;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  imem_fetch_if #(.ADDR_W(32)) if1 ();
  imem_fetch_if #(.ADDR_W(32)) if2 ();
  imem_fetch_if #(.ADDR_W(32)) if3 ();

  assign if1.req_valid = req_valid;
  assign if1.req_addr  = req_addr;
  assign if1.rsp_ready = rsp_ready;
  assign if1.ld_en     = ld_en;
  assign if1.ld_addr   = ld_addr;
  assign if1.ld_data   = ld_data;
  assign if2.req_valid = req_valid;
  assign if2.req_addr  = req_addr;
  assign if2.rsp_ready = rsp_ready;
  assign if2.ld_en     = ld_en;
  assign if2.ld_addr   = ld_addr;
  assign if2.ld_data   = ld_data;
  assign if3.req_valid = req_valid;
  assign if3.req_addr  = req_addr;
  assign if3.rsp_ready = rsp_ready;
  assign if3.ld_en     = ld_en;
  assign if3.ld_addr   = ld_addr;
  assign if3.ld_data   = ld_data;

  imem_fetch #(.DEPTH_BYTES(DEPTH), .ADDR_W(32), .LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );
  imem_fetch #(.DEPTH_BYTES(DEPTH), .ADDR_W(32), .LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .bus(if2)
  );
  imem_fetch #(.DEPTH_BYTES(DEPTH), .ADDR_W(32), .LATENCY(3)) u_l3 (
    .clk(clk), .rst_n(rst_n), .bus(if3)
  );

  logic [2:0]  rv, rr, rf;
  logic [31:0] ri [3];
  logic [31:0] ra [3];
  assign rv    = {if3.rsp_valid, if2.rsp_valid, if1.rsp_valid};
  assign rr    = {if3.req_ready, if2.req_ready, if1.req_ready};
  assign rf    = {if3.rsp_fault, if2.rsp_fault, if1.rsp_fault};
  assign ri[0] = if1.rsp_instr;
  assign ri[1] = if2.rsp_instr;
  assign ri[2] = if3.rsp_instr;
  assign ra[0] = if1.rsp_addr;
  assign ra[1] = if2.rsp_addr;
  assign ra[2] = if3.rsp_addr;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // Each accepted request is an entry with the number of advancing edges it still needs
  // before it is visible; stalls freeze every entry of that instance.
  typedef struct {
    int          d;
    logic [31:0] instr;
    logic        fault;
    logic [31:0] addr;
    int          rem;
  } ent_t;

  ent_t       q[$];
  logic [7:0] mmem [DEPTH];
  int         lat [3] = '{1, 2, 3};
  bit         armed = 0;
  bit         just_rst = 0;

  function automatic int head_idx(input int d);
    foreach (q[i]) if (q[i].d == d) return i;
    return -1;
  endfunction

  function automatic bit mvalid(input int d);
    int h;
    h = head_idx(d);
    return h >= 0 && q[h].rem == 0;
  endfunction

  function automatic void model_word(input logic [31:0] a, output logic [31:0] w,
                                     output logic f);
    longint unsigned top;
    top = 64'(a) + 64'd3;
    f = top >= 64'(DEPTH);
`ifdef IMEM_ALIGN_CHECK_EN
    if (a % 4 != 0) f = 1'b1;
`endif
    w = '0;
    if (!f) for (int k = 0; k < 4; k++) w = {w[23:0], mmem[int'(a) + k]};
  endfunction

  initial begin : model_proc
    ent_t e;
    bit   st;
    int   h;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        q.delete();
        armed    = 1;
        just_rst = 1;
      end else begin
        just_rst = 0;
        for (int d = 0; d < 3; d++) begin
          st = mvalid(d) && !rsp_ready;
          if (!st) begin
            h = head_idx(d);
            if (h >= 0 && q[h].rem == 0) q.delete(h);
            foreach (q[i]) if (q[i].d == d && q[i].rem > 0) q[i].rem--;
            if (req_valid && !ld_en) begin
              e.d    = d;
              model_word(req_addr, e.instr, e.fault);
              e.addr = req_addr;
              e.rem  = lat[d] - 1;
              q.push_back(e);
            end
          end
        end
      end
      if (ld_en && ld_addr < 32'(DEPTH)) mmem[ld_addr[8:0]] = ld_data;
    end
  end

  initial begin : check_proc
    int h;
    bit mv;
    forever begin
      @(negedge clk);
      if (armed) begin
        for (int d = 0; d < 3; d++) begin
          h  = head_idx(d);
          mv = h >= 0 && q[h].rem == 0;
          chk($sformatf("L%0d rsp_valid", d + 1), 32'(rv[d]), 32'(mv));
          if (mv) begin
            chk($sformatf("L%0d rsp_instr", d + 1), ri[d], q[h].instr);
            chk($sformatf("L%0d rsp_fault", d + 1), 32'(rf[d]), 32'(q[h].fault));
            chk($sformatf("L%0d rsp_addr", d + 1), ra[d], q[h].addr);
          end
          chk($sformatf("L%0d req_ready", d + 1), 32'(rr[d]),
              32'(!(mv && !rsp_ready) && !ld_en));
          if (just_rst) begin
            chk($sformatf("L%0d reset instr", d + 1), ri[d], 32'h0);
            chk($sformatf("L%0d reset fault", d + 1), 32'(rf[d]), 32'h0);
            chk($sformatf("L%0d reset addr", d + 1), ra[d], 32'h0);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [7:0] v);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = v;
    tick();
    ld_en   = 1'b0;
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    repeat (5) tick();
  endtask

  task automatic wait_rsp(input int d, output logic [31:0] instr, output logic [31:0] addr);
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (rv[d]) begin
        instr = ri[d];
        addr  = ra[d];
        return;
      end
    end
    instr = 'x;
    addr  = 'x;
    chk($sformatf("L%0d response timeout", d + 1), 32'h0, 32'h1);
  endtask

  // Holds the request until the LATENCY=3 instance takes it.
  task automatic issue3(input logic [31:0] a);
    bit r;
    req_valid = 1'b1;
    req_addr  = a;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      r = rr[2];
      tick();
      if (r) return;
    end
    chk("L3 accept timeout", 32'h0, 32'h1);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        fault;
  } vec_t;

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0]  pat [8] = '{8'h22, 8'h72, 8'hF0, 8'h04, 8'hFA, 8'hA2, 8'h3B, 8'hDA};
    logic [7:0]  top [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    vec_t        vt [9];
    logic [31:0] got_i, got_a, held_i, held_a;
    logic [31:0] seen[$];
    int          cnt;

    vt[0] = '{32'd0,         32'h2272F004, 1'b0};
    vt[1] = '{32'd4,         32'hFAA23BDA, 1'b0};
`ifdef IMEM_ALIGN_CHECK_EN
    vt[2] = '{32'd1,         32'h0,        1'b1};
    vt[3] = '{32'd2,         32'h0,        1'b1};
`else
    vt[2] = '{32'd1,         32'h72F004FA, 1'b0};
    vt[3] = '{32'd2,         32'hF004FAA2, 1'b0};
`endif
    vt[4] = '{32'd508,       32'h11223344, 1'b0};
    vt[5] = '{32'd509,       32'h0,        1'b1};
    vt[6] = '{32'hFFFFFFFD,  32'h0,        1'b1};
    vt[7] = '{32'hFFFFFFFC,  32'h0,        1'b1};
    vt[8] = '{32'd512,       32'h0,        1'b1};

    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    tick(); tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset rsp_valid", 32'(rv), 32'h0);
    chk("post-reset req_ready", 32'(rr), 32'h7);

    // Program load; last two loads are out of range and must not alias to bytes 3 / 511.
    tick();
    for (int a = 0; a < DEPTH; a++) begin
      if (a < 8)        load(32'(a), pat[a]);
      else if (a >= 508) load(32'(a), top[a - 508]);
      else              load(32'(a), 8'($urandom));
    end
    load(32'd515, 8'hEE);
    load(32'hFFFFFFFF, 8'hEE);

    // Table: single fetches on the LATENCY=1 instance, response in the following cycle.
    for (int i = 0; i < 9; i++) begin
      drain();
      req_valid = 1'b1;
      req_addr  = vt[i].addr;
      tick();
      req_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("tbl%0d valid", i), 32'(rv[0]), 32'h1);
      chk($sformatf("tbl%0d instr", i), ri[0], vt[i].instr);
      chk($sformatf("tbl%0d fault", i), 32'(rf[0]), 32'(vt[i].fault));
      chk($sformatf("tbl%0d addr", i), ra[0], vt[i].addr);
    end

    // Back-to-back fetches 0 and 4 on LATENCY=1.
    drain();
    req_valid = 1'b1;
    req_addr  = 32'd0;
    tick();
    req_addr  = 32'd4;
    @(negedge clk);
    chk("b2b first instr", ri[0], 32'h2272F004);
    chk("b2b first addr", ra[0], 32'd0);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b second valid", 32'(rv[0]), 32'h1);
    chk("b2b second instr", ri[0], 32'hFAA23BDA);
    chk("b2b second addr", ra[0], 32'd4);

    // Stall on LATENCY=3: four requests, consumer holds off for five cycles.
    drain();
    rsp_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) issue3(32'(4 * i));
        req_valid = 1'b0;
      end
      begin
        wait_rsp(2, held_i, held_a);
        for (int c = 0; c < 5; c++) begin
          chk("stall req_ready", 32'(rr[2]), 32'h0);
          chk("stall rsp_valid", 32'(rv[2]), 32'h1);
          chk("stall instr stable", ri[2], held_i);
          chk("stall addr stable", ra[2], held_a);
          if (c < 4) @(negedge clk);
        end
        tick();
        rsp_ready = 1'b1;
        for (int n = 0; n < 30; n++) begin
          @(negedge clk);
          if (rv[2] && rsp_ready) seen.push_back(ra[2]);
        end
      end
    join
    chk("stall response count", 32'(seen.size()), 32'd4);
    for (int i = 0; i < 4 && i < seen.size(); i++)
      chk($sformatf("stall order %0d", i), seen[i], 32'(4 * i));

    // Load behind an in-flight fetch on LATENCY=3.
    drain();
    req_valid = 1'b1;
    req_addr  = 32'd0;
    tick();
    req_valid = 1'b0;
    ld_en     = 1'b1;
    ld_addr   = 32'd0;
    ld_data   = 8'h99;
    @(negedge clk);
    chk("ld blocks req_ready", 32'(rr[2]), 32'h0);
    tick();
    ld_en = 1'b0;
    wait_rsp(2, got_i, got_a);
    chk("in-flight unaffected by load", got_i, 32'h2272F004);
    drain();
    req_valid = 1'b1;
    req_addr  = 32'd0;
    tick();
    req_valid = 1'b0;
    wait_rsp(2, got_i, got_a);
    chk("fetch after load", got_i, 32'h9972F004);

    // Reset with two requests in flight on LATENCY=2.
    drain();
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'd4;
    tick();
    req_addr  = 32'd8;
    tick();
    req_valid = 1'b0;
    rst_n     = 1'b0;
    tick();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("reset flush rsp_valid", 32'(rv[1]), 32'h0);
    cnt = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (rv[1]) cnt++;
    end
    chk("no stale response", 32'(cnt), 32'h0);
    tick();
    req_valid = 1'b1;
    req_addr  = 32'd0;
    tick();
    req_valid = 1'b0;
    wait_rsp(1, got_i, got_a);
    chk("store kept over reset", got_i, 32'h9972F004);

    // Random traffic, all three instances checked by the model.
    drain();
    for (int n = 0; n < 600; n++) begin
      req_valid = $urandom_range(0, 3) != 0;
      case ($urandom_range(0, 3))
        0:       req_addr = 32'($urandom_range(0, DEPTH - 1));
        1:       req_addr = 32'($urandom_range(500, 520));
        2:       req_addr = 32'(4 * $urandom_range(0, 127));
        default: req_addr = $urandom | 32'hFFFF_FF00;
      endcase
      rsp_ready = $urandom_range(0, 3) != 0;
      ld_en     = $urandom_range(0, 9) == 0;
      ld_addr   = 32'($urandom_range(0, 600));
      ld_data   = 8'($urandom);
      rst_n     = $urandom_range(0, 99) != 0;
      tick();
    end
    rst_n = 1'b1;
    ld_en = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
